// File: rtl/d_flip_flop_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dff_pkg
//  Description : Shared constants for the flip-flop library: default data
//                width and the default reset bit, which is replicated to form
//                the all-zeros default RESET_VALUE.
//  Optional    : none (DFF_CHANGE_FLAG_EN is consumed by the interface/top)
//  Revision    : 1.0 - initial release
// ============================================================================
package dff_pkg;

    localparam int   DFF_DEFAULT_WIDTH     = 1;
    localparam logic DFF_DEFAULT_RESET_BIT = 1'b0;

endpackage : dff_pkg
`default_nettype wire

// File: rtl/d_flip_flop_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : d_flip_flop_reg_if
//  Description : Data-path bundle of the D flip-flop register.
//                  en      - load enable (only honoured when HAS_EN=1)
//                  d       - WIDTH-bit data input
//                  q       - WIDTH-bit registered data
//                  qn      - bitwise complement of q
//                  changed - one-cycle flag, q took a new value
//                            (present only with DFF_CHANGE_FLAG_EN defined)
//                master : drives en/d, observes q/qn(/changed)
//                slave  : the register itself
//  Optional    : DFF_CHANGE_FLAG_EN adds the 'changed' signal
//  Revision    : 1.0 - initial release
// ============================================================================
interface d_flip_flop_reg_if
    import dff_pkg::*;
#(
    parameter int WIDTH = DFF_DEFAULT_WIDTH
) ();

    logic             en;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
`ifdef DFF_CHANGE_FLAG_EN
    logic             changed;

    modport master (output en, output d, input  q, input  qn, input  changed);
    modport slave  (input  en, input  d, output q, output qn, output changed);
`else
    modport master (output en, output d, input  q, input  qn);
    modport slave  (input  en, input  d, output q, output qn);
`endif

endinterface : d_flip_flop_reg_if
`default_nettype wire

// File: rtl/d_flip_flop_reg_bit.sv
`default_nettype none
// ============================================================================
//  Module      : dff_bit
//  Description : Single-bit rising-edge D cell with synchronous active-low
//                reset (priority over enable) and a combinational complement.
//                Ports: clk, rst_n, en, d -> q, qn. RESET_BIT sets the value
//                loaded by reset.
//  Optional    : none
//  Revision    : 1.0 - initial release
// ============================================================================
module dff_bit #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic q,
    output logic qn
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= RESET_BIT;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q  = r_q;
    // Derived from the stored bit so q/qn can never disagree, even in reset.
    assign qn = ~r_q;

endmodule : dff_bit
`default_nettype wire

// File: rtl/d_flip_flop_reg.sv
`default_nettype none
// ============================================================================
//  Module      : d_flip_flop_reg
//  Description : WIDTH-bit positive-edge D register with true and complement
//                outputs, built from WIDTH dff_bit cells.
//                Ports: clk   - rising-edge clock
//                       rst_n - synchronous active-low reset
//                       bus   - d_flip_flop_reg_if.slave (en, d, q, qn
//                               and optionally changed)
//                Parameters: WIDTH, RESET_VALUE, HAS_EN (0 = load every edge)
//  Optional    : DFF_CHANGE_FLAG_EN - registered 'changed' flag, high for one
//                cycle after an edge at which q took a different value
//  Revision    : 1.0 - initial release
// ============================================================================
module d_flip_flop_reg
    import dff_pkg::*;
#(
    parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{DFF_DEFAULT_RESET_BIT}},
    parameter bit               HAS_EN      = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    d_flip_flop_reg_if.slave    bus
);

    logic             w_load;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qn;

    // Without the enable option the register loads on every edge and en is
    // deliberately ignored.
    assign w_load = HAS_EN ? bus.en : 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_bit #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (w_load),
            .d     (bus.d[i]),
            .q     (w_q[i]),
            .qn    (w_qn[i])
        );
    end

    assign bus.q  = w_q;
    assign bus.qn = w_qn;

`ifdef DFF_CHANGE_FLAG_EN
    logic r_changed;

    // Flag is computed from the value about to be loaded versus the current
    // q, so it rises in the same edge that updates q. The reset edge always
    // clears it, even if reset itself alters q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= w_load && (bus.d != w_q);
        end
    end

    assign bus.changed = r_changed;
`endif

endmodule : d_flip_flop_reg
`default_nettype wire

// File: tb/tb_d_flip_flop_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_d_flip_flop_reg
//  Description : Self-checking bench for d_flip_flop_reg. Three instances:
//                  ua - WIDTH=8, HAS_EN=1, RESET_VALUE=8'h00
//                  ub - WIDTH=1, HAS_EN=0, RESET_VALUE=1
//                  uc - package defaults (WIDTH=1, HAS_EN=0, reset 0)
//                A directed vector table, hand-written glitch and change-flag
//                sequences, and a randomized phase against a behavioural model.
//  Optional    : DFF_CHANGE_FLAG_EN enables checks of 'changed'
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_d_flip_flop_reg;
    import dff_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;   // rising edges at 5, 15, 25 ns ...

    d_flip_flop_reg_if #(.WIDTH(8)) ifa ();
    d_flip_flop_reg_if #(.WIDTH(1)) ifb ();
    d_flip_flop_reg_if #(.WIDTH(1)) ifc ();

    d_flip_flop_reg #(
        .WIDTH       (8),
        .RESET_VALUE (8'h00),
        .HAS_EN      (1'b1)
    ) ua (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    d_flip_flop_reg #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1),
        .HAS_EN      (1'b0)
    ) ub (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    d_flip_flop_reg uc (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state: what each register should hold, and whether
    // the most recent edge changed it.
    logic [7:0] ma;
    logic       mb, mc;
    logic       cha, chb, chc;

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply inputs, take one rising edge, then advance the model by the
    // register rules: reset wins, otherwise load when enabled.
    task automatic drive_edge(input logic r, input logic e, input logic [7:0] a, input logic b);
        rst_n   = r;
        ifa.en  = e;
        ifb.en  = e;
        ifc.en  = e;
        ifa.d   = a;
        ifb.d   = b;
        ifc.d   = b;
        @(posedge clk);
        #1;
        if (!r) begin
            ma  = 8'h00;
            mb  = 1'b1;
            mc  = 1'b0;
            cha = 1'b0;
            chb = 1'b0;
            chc = 1'b0;
        end else begin
            cha = e && (a != ma);
            chb = (b != mb);
            chc = (b != mc);
            if (e) ma = a;
            mb = b;
            mc = b;
        end
    endtask

    task automatic check_model(input string tag);
        chk8({tag, "_qa"},  ifa.q,  ma);
        chk8({tag, "_qna"}, ifa.qn, ~ma);
        chk1({tag, "_qb"},  ifb.q,  mb);
        chk1({tag, "_qnb"}, ifb.qn, !mb);
        chk1({tag, "_qc"},  ifc.q,  mc);
        chk1({tag, "_qnc"}, ifc.qn, !mc);
`ifdef DFF_CHANGE_FLAG_EN
        chk1({tag, "_cha"}, ifa.changed, cha);
        chk1({tag, "_chb"}, ifb.changed, chb);
        chk1({tag, "_chc"}, ifc.changed, chc);
`endif
    endtask

    typedef struct {
        logic       r;
        logic       e;
        logic [7:0] a;
        logic       b;
        logic [7:0] qa;
        logic       qb;
        logic       qc;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // Directed table: expected values written out by hand.
        tbl[0]  = '{r:1'b0, e:1'b1, a:8'hFF, b:1'b1, qa:8'h00, qb:1'b1, qc:1'b0}; // reset, d=1
        tbl[1]  = '{r:1'b0, e:1'b1, a:8'hFF, b:1'b1, qa:8'h00, qb:1'b1, qc:1'b0}; // reset held
        tbl[2]  = '{r:1'b1, e:1'b1, a:8'h00, b:1'b0, qa:8'h00, qb:1'b0, qc:1'b0}; // capture 0
        tbl[3]  = '{r:1'b1, e:1'b1, a:8'h3C, b:1'b1, qa:8'h3C, qb:1'b1, qc:1'b1}; // capture 1
        tbl[4]  = '{r:1'b1, e:1'b1, a:8'h3C, b:1'b0, qa:8'h3C, qb:1'b0, qc:1'b0}; // capture 0
        tbl[5]  = '{r:1'b1, e:1'b0, a:8'hFF, b:1'b1, qa:8'h3C, qb:1'b1, qc:1'b1}; // en=0 hold
        tbl[6]  = '{r:1'b1, e:1'b0, a:8'hFF, b:1'b1, qa:8'h3C, qb:1'b1, qc:1'b1};
        tbl[7]  = '{r:1'b1, e:1'b0, a:8'hFF, b:1'b0, qa:8'h3C, qb:1'b0, qc:1'b0};
        tbl[8]  = '{r:1'b1, e:1'b1, a:8'hFF, b:1'b1, qa:8'hFF, qb:1'b1, qc:1'b1}; // en=1 load
        tbl[9]  = '{r:1'b1, e:1'b1, a:8'hA5, b:1'b0, qa:8'hA5, qb:1'b0, qc:1'b0};
        tbl[10] = '{r:1'b0, e:1'b1, a:8'h5A, b:1'b0, qa:8'h00, qb:1'b1, qc:1'b0}; // mid reset
        tbl[11] = '{r:1'b1, e:1'b1, a:8'h5A, b:1'b0, qa:8'h5A, qb:1'b0, qc:1'b0}; // release
        tbl[12] = '{r:1'b0, e:1'b0, a:8'h77, b:1'b1, qa:8'h00, qb:1'b1, qc:1'b0}; // reset beats en=0
        tbl[13] = '{r:1'b1, e:1'b0, a:8'h77, b:1'b1, qa:8'h00, qb:1'b1, qc:1'b1}; // en ignored on ub/uc

        for (int i = 0; i < 14; i++) begin
            drive_edge(tbl[i].r, tbl[i].e, tbl[i].a, tbl[i].b);
            chk8($sformatf("tbl%0d_qa", i),  ifa.q,  tbl[i].qa);
            chk8($sformatf("tbl%0d_qna", i), ifa.qn, ~tbl[i].qa);
            chk1($sformatf("tbl%0d_qb", i),  ifb.q,  tbl[i].qb);
            chk1($sformatf("tbl%0d_qnb", i), ifb.qn, !tbl[i].qb);
            chk1($sformatf("tbl%0d_qc", i),  ifc.q,  tbl[i].qc);
            chk1($sformatf("tbl%0d_qnc", i), ifc.qn, !tbl[i].qc);
            check_model($sformatf("tbl%0d", i));
        end

        // Glitch sequence: d wiggles across the falling edge and twice more
        // inside the cycle; only the value present at the rising edge counts.
        drive_edge(1'b1, 1'b1, 8'h00, 1'b0);           // now at edge+1
        check_model("gl_start");
        #3;                                             // edge+4
        ifa.d = 8'hC3; ifb.d = 1'b1; ifc.d = 1'b1;
        #2;                                             // edge+6, past negedge
        chk8("gl_negedge_qa", ifa.q, 8'h00);
        chk1("gl_negedge_qc", ifc.q, 1'b0);
        #1;                                             // edge+7
        ifa.d = 8'h00; ifb.d = 1'b0; ifc.d = 1'b0;
        #1;                                             // edge+8
        ifa.d = 8'h96; ifb.d = 1'b1; ifc.d = 1'b1;
        #1;                                             // edge+9
        chk8("gl_mid_qa", ifa.q, 8'h00);
        chk1("gl_mid_qb", ifb.q, 1'b0);
        drive_edge(1'b1, 1'b1, 8'h96, 1'b1);
        chk8("gl_end_qa", ifa.q, 8'h96);
        chk1("gl_end_qc", ifc.q, 1'b1);
        check_model("gl_end");

`ifdef DFF_CHANGE_FLAG_EN
        // Change-flag sequence on uc after a fresh reset.
        begin
            int dv[5] = '{0, 0, 1, 1, 0};
            int ev[5] = '{0, 0, 1, 0, 1};
            drive_edge(1'b0, 1'b1, 8'hFF, 1'b1);
            chk1("cf_reset_chc", ifc.changed, 1'b0);
            chk1("cf_reset_cha", ifa.changed, 1'b0);
            for (int i = 0; i < 5; i++) begin
                drive_edge(1'b1, 1'b1, 8'h00, dv[i][0]);
                chk1($sformatf("cf%0d_chc", i), ifc.changed, ev[i][0]);
            end
        end
`endif

        // Randomized phase against the model.
        for (int i = 0; i < 300; i++) begin
            logic       r;
            logic       e;
            logic [7:0] a;
            logic       b;
            r = ($urandom_range(0, 9) != 0);
            e = $urandom_range(0, 1) == 1;
            a = 8'($urandom);
            b = $urandom_range(0, 1) == 1;
            drive_edge(r, e, a, b);
            check_model($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_d_flip_flop_reg
`default_nettype wire
